// File: rtl/reset_sequencer.sv
// Reset-domain sequencer: merges software/watchdog requests, stretches reset, and releases
// per-domain active-low resets in order. Watchdog is built only with RESET_SEQ_WDOG_EN.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGE_GAP      = 8,
    parameter int unsigned WDOG_CYCLES    = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sw_rst_req_i,
    input  logic                  wdog_kick_i,
    output logic [NUM_STAGES-1:0] stage_rst_n_o,
    output logic                  seq_done_o,
    output logic [1:0]            rst_cause_o
);

    localparam int unsigned StretchW = $clog2(STRETCH_CYCLES > 2 ? STRETCH_CYCLES : 2);
    localparam int unsigned GapW     = $clog2(STAGE_GAP > 2 ? STAGE_GAP : 2);
    localparam logic [StretchW-1:0] StretchLast = StretchW'(STRETCH_CYCLES - 1);
    localparam logic [GapW-1:0]     GapLast     = GapW'(STAGE_GAP - 1);

    typedef enum logic [1:0] {StAssert, StRelease, StRun} state_e;

    state_e                state_q, state_d;
    logic [StretchW-1:0]   stretch_q, stretch_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic [1:0]            cause_q, cause_d;
    logic                  wdog_expire;
    logic                  req;

`ifdef RESET_SEQ_WDOG_EN
    localparam int unsigned WdogW = $clog2(WDOG_CYCLES > 2 ? WDOG_CYCLES : 2);
    localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

    logic [WdogW-1:0] wdog_q, wdog_d;

    // A kick on the terminal edge wins over expiry.
    always_comb begin
        wdog_d      = '0;
        wdog_expire = 1'b0;
        if (state_q == StRun && !wdog_kick_i) begin
            if (wdog_q == WdogLast) begin
                wdog_expire = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_kick;
    assign unused_kick = wdog_kick_i;
    assign wdog_expire = 1'b0;
`endif

    assign req = sw_rst_req_i | wdog_expire;

    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        gap_d     = gap_q;
        stage_d   = stage_q;
        done_d    = done_q;
        cause_d   = cause_q;
        if (req) begin
            state_d   = StAssert;
            stretch_d = '0;
            gap_d     = '0;
            stage_d   = '0;
            done_d    = 1'b0;
            cause_d   = wdog_expire ? 2'b10 : 2'b01;
        end else begin
            unique case (state_q)
                StAssert: begin
                    stage_d = '0;
                    if (stretch_q == StretchLast) begin
                        stretch_d = '0;
                        gap_d     = '0;
                        stage_d   = NUM_STAGES'(1);
                        if (NUM_STAGES == 1) begin
                            state_d = StRun;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StRelease;
                        end
                    end else begin
                        stretch_d = stretch_q + 1'b1;
                    end
                end
                StRelease: begin
                    if (gap_q == GapLast) begin
                        gap_d   = '0;
                        // Shift in a one so stages can only release in order.
                        stage_d = (stage_q << 1) | NUM_STAGES'(1);
                        if (stage_d[NUM_STAGES-1]) begin
                            state_d = StRun;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                StRun: begin
                    stage_d = '1;
                    done_d  = 1'b1;
                end
                default: state_d = StAssert;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StAssert;
            stretch_q <= '0;
            gap_q     <= '0;
            stage_q   <= '0;
            done_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            stretch_q <= stretch_d;
            gap_q     <= gap_d;
            stage_q   <= stage_d;
            done_q    <= done_d;
            cause_q   <= cause_d;
        end
    end

    assign stage_rst_n_o = stage_q;
    assign seq_done_o    = done_q;
    assign rst_cause_o   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: compares every cycle against a timing model that
// counts edges since the last reset event.
module tb_reset_sequencer;

    localparam int N = 3;
    localparam int S = 16;
    localparam int G = 8;
    localparam int W = 64;
`ifdef RESET_SEQ_WDOG_EN
    localparam bit WdogEn = 1'b1;
`else
    localparam bit WdogEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sw  = 1'b0;
    logic         kick = 1'b0;
    logic [N-1:0] stage_rst_n;
    logic         seq_done;
    logic [1:0]   rst_cause;

    reset_sequencer #(
        .NUM_STAGES    (N),
        .STRETCH_CYCLES(S),
        .STAGE_GAP     (G),
        .WDOG_CYCLES   (W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sw_rst_req_i (sw),
        .wdog_kick_i  (kick),
        .stage_rst_n_o(stage_rst_n),
        .seq_done_o   (seq_done),
        .rst_cause_o  (rst_cause)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: edges since last reset event, edges in RUN since entry/kick, last cause.
    int         since  = 0;
    int         wsince = 0;
    logic [1:0] m_cause = 2'd0;

    function automatic int released(input int s);
        int r;
        if (s < S) return 0;
        r = (s - S) / G + 1;
        return (r > N) ? N : r;
    endfunction

    function automatic logic [N-1:0] exp_stage();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < released(since); i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_done();
        return released(since) == N;
    endfunction

    task automatic tick(input logic s, input logic k);
        bit run_pre;
        bit expire;
        sw   = s;
        kick = k;
        @(posedge clk);
        run_pre = (released(since) == N);
        expire  = WdogEn && run_pre && !k && (wsince + 1 == W);
        if (s || expire) begin
            since   = 0;
            wsince  = 0;
            m_cause = expire ? 2'd2 : 2'd1;
        end else begin
            since = since + 1;
            if (run_pre) wsince = k ? 0 : wsince + 1;
            else wsince = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sw   = 1'b0;
        kick = 1'b0;
        @(posedge clk);
        #3;
        since   = 0;
        wsince  = 0;
        m_cause = 2'd0;
        rst     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp += 3;
        if (stage_rst_n !== '0) begin
            n_err++;
            $display("FAIL reset_stage: got %b want %b", stage_rst_n, {N{1'b0}});
        end
        if (seq_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: got %b want 0", seq_done);
        end
        if (rst_cause !== 2'b00) begin
            n_err++;
            $display("FAIL reset_cause: got %b want 00", rst_cause);
        end
    endtask

    task automatic test_power_up();
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            tick(1'b0, 1'b0);
            n_cmp += 3;
            if (stage_rst_n !== exp_stage()) begin
                n_err++;
                $display("FAIL pwr_stage e%0d: got %b want %b", e, stage_rst_n, exp_stage());
            end
            if (seq_done !== exp_done()) begin
                n_err++;
                $display("FAIL pwr_done e%0d: got %b want %b", e, seq_done, exp_done());
            end
            if (rst_cause !== m_cause) begin
                n_err++;
                $display("FAIL pwr_cause e%0d: got %b want %b", e, rst_cause, m_cause);
            end
        end
    endtask

    task automatic test_sw_in_run();
        do_reset();
        for (int e = 1; e <= 100; e++) begin
            tick(e == 50, 1'b0);
            n_cmp += 3;
            if (stage_rst_n !== exp_stage()) begin
                n_err++;
                $display("FAIL swrun_stage e%0d: got %b want %b", e, stage_rst_n, exp_stage());
            end
            if (seq_done !== exp_done()) begin
                n_err++;
                $display("FAIL swrun_done e%0d: got %b want %b", e, seq_done, exp_done());
            end
            if (rst_cause !== m_cause) begin
                n_err++;
                $display("FAIL swrun_cause e%0d: got %b want %b", e, rst_cause, m_cause);
            end
        end
    endtask

    task automatic test_mid_sequence();
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            tick(e == 20, 1'b0);
            n_cmp += 2;
            if (stage_rst_n !== exp_stage()) begin
                n_err++;
                $display("FAIL mid_stage e%0d: got %b want %b", e, stage_rst_n, exp_stage());
            end
            if (rst_cause !== m_cause) begin
                n_err++;
                $display("FAIL mid_cause e%0d: got %b want %b", e, rst_cause, m_cause);
            end
        end
    endtask

    task automatic test_held();
        do_reset();
        for (int e = 1; e <= 120; e++) begin
            tick(e > 40 && e <= 80, 1'b0);
            n_cmp += 2;
            if (stage_rst_n !== exp_stage()) begin
                n_err++;
                $display("FAIL held_stage e%0d: got %b want %b", e, stage_rst_n, exp_stage());
            end
            if (seq_done !== exp_done()) begin
                n_err++;
                $display("FAIL held_done e%0d: got %b want %b", e, seq_done, exp_done());
            end
        end
    endtask

    // Scenario 0: no kicks; 1: kick every 32; 2: sw request on the expiry edge (edge 96).
    task automatic test_watchdog();
        for (int sc = 0; sc < 3; sc++) begin
            do_reset();
            for (int e = 1; e <= 300; e++) begin
                tick(sc == 2 && e == 96, sc == 1 && e % 32 == 0);
                n_cmp += 3;
                if (stage_rst_n !== exp_stage()) begin
                    n_err++;
                    $display("FAIL wdog%0d_stage e%0d: got %b want %b", sc, e, stage_rst_n,
                             exp_stage());
                end
                if (seq_done !== exp_done()) begin
                    n_err++;
                    $display("FAIL wdog%0d_done e%0d: got %b want %b", sc, e, seq_done,
                             exp_done());
                end
                if (rst_cause !== m_cause) begin
                    n_err++;
                    $display("FAIL wdog%0d_cause e%0d: got %b want %b", sc, e, rst_cause,
                             m_cause);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int e = 1; e <= 3000; e++) begin
            tick($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0);
            n_cmp += 3;
            if (stage_rst_n !== exp_stage()) begin
                n_err++;
                $display("FAIL rnd_stage e%0d: got %b want %b", e, stage_rst_n, exp_stage());
            end
            if (seq_done !== exp_done()) begin
                n_err++;
                $display("FAIL rnd_done e%0d: got %b want %b", e, seq_done, exp_done());
            end
            if (rst_cause !== m_cause) begin
                n_err++;
                $display("FAIL rnd_cause e%0d: got %b want %b", e, rst_cause, m_cause);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int e = 1; e <= 30; e++) tick(e == 10, 1'b0);
        n_cmp += 2;
        if (stage_rst_n !== exp_stage()) begin
            n_err++;
            $display("FAIL async_pre_stage: got %b want %b", stage_rst_n, exp_stage());
        end
        if (rst_cause !== m_cause) begin
            n_err++;
            $display("FAIL async_pre_cause: got %b want %b", rst_cause, m_cause);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp += 3;
        if (stage_rst_n !== '0) begin
            n_err++;
            $display("FAIL async_stage: got %b want %b", stage_rst_n, {N{1'b0}});
        end
        if (seq_done !== 1'b0) begin
            n_err++;
            $display("FAIL async_done: got %b want 0", seq_done);
        end
        if (rst_cause !== 2'b00) begin
            n_err++;
            $display("FAIL async_cause: got %b want 00", rst_cause);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_sw_in_run();
        test_mid_sequence();
        test_held();
        test_watchdog();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset-domain controller sitting directly downstream of the board-level reset synchronizer. It merges the synchronized system reset with software and watchdog reset requests, stretches every reset event to a minimum width, and releases a set of per-domain active-low resets in a fixed order: stage 0 (sensor/SPI), then stage 1 (PWM/motor drive), then stage 2 (tour/command logic). It also reports the cause of the most recent reset.

## Interface
- NUM_STAGES, 3, number of sequenced reset domains (1–8)
- STRETCH_CYCLES, 16, cycles all domains stay asserted after the last reset source clears (≥2)
- STAGE_GAP, 8, cycles between consecutive stage releases (≥1)
- WDOG_CYCLES, 1024, watchdog timeout in cycles (only used with the watchdog compiled in)

- clk  input  1  system clock; all logic is on the rising edge
- rst  input  1  asynchronous, active-high reset (already synchronized upstream)
- sw_rst_req  input  1  software reset request, single-cycle pulse or level
- wdog_kick  input  1  watchdog service pulse
- stage_rst_n  output  NUM_STAGES  per-domain active-low resets, registered
- seq_done  output  1  high once all stages have been released, registered
- rst_cause  output  2  cause of the last reset: 00 external/power, 01 software, 10 watchdog; 11 is never driven

## Operation
- Reset values while rst is high: state ASSERT, stage_rst_n all 0, seq_done 0, rst_cause 00, all counters 0. Outputs go low asynchronously when rst asserts.
- FSM states: ASSERT, RELEASE, RUN.
- ASSERT:
  - All stage_rst_n bits are 0 and the stretch counter increments every cycle.
  - A request in this state clears the counter to 0.
  - When the counter reaches STRETCH_CYCLES-1, go to RELEASE. On that edge stage_rst_n[0] goes to 1 and the gap counter is cleared.
- RELEASE:
  - The gap counter increments every cycle.
  - At STAGE_GAP-1, the next stage bit is set and the counter clears.
  - Stages release strictly in order and are never released out of order.
  - When the last stage is released, go to RUN and set seq_done on the same edge.
- RUN: all stage_rst_n bits are 1 and seq_done is 1.
- Request, defined as sw_rst_req high or a watchdog expiry:
  - In any state, the next edge forces state ASSERT, clears stage_rst_n and seq_done, and clears all counters.
  - rst_cause updates on that same edge.
  - A level-held sw_rst_req keeps the block in ASSERT. Release begins STRETCH_CYCLES cycles after the request drops.
- Simultaneous software and watchdog requests: watchdog has priority and rst_cause becomes 10.
- rst_cause holds its value until the next request or rst. It never changes in RUN without a request.
- Counter widths are $clog2 of the larger of the relevant parameter and 2. Counters must not wrap before their terminal value.

## Timing
- Defaults, with edge 1 as the first rising edge with rst low:
  - stage_rst_n[0] rises after edge 16.
  - stage_rst_n[1] rises after edge 24.
  - stage_rst_n[2] and seq_done rise after edge 32.
- General formula: stage k releases after edge STRETCH_CYCLES + k·STAGE_GAP.
- Request-to-assert latency: 1 cycle. A request sampled high at edge n gives all-zero stage_rst_n after edge n.
- If rst is asserted mid-sequence, outputs return to reset values immediately, asynchronously.

## Configuration
- Macro: RESET_SEQ_WDOG_EN.
- Defined:
  - A watchdog counter runs only in RUN and clears on wdog_kick or on leaving RUN.
  - If WDOG_CYCLES cycles pass in RUN without a kick, a watchdog request is raised on the edge where the counter reaches WDOG_CYCLES-1.
  - A kick on that same edge wins and no request is raised.
- Undefined: no watchdog logic is built, wdog_kick is ignored (the port remains), and rst_cause never reads 10.

## Test plan
- Power-up, defaults: deassert rst and hold sw_rst_req=0 -> stage_rst_n goes 000→001 after edge 16, 011 after edge 24, 111 plus seq_done after edge 32, with rst_cause=00.
- Software reset in RUN: pulse sw_rst_req for 1 cycle at edge 50 -> stage_rst_n=000 and rst_cause=01 after edge 50, then re-release at edges 66/74/82.
- Mid-sequence request: assert sw_rst_req at edge 20 (stage 0 already released) -> all stages 0 after edge 20, and stage 0 releases again after edge 36.
- Held request: hold sw_rst_req high for 40 cycles -> stage_rst_n stays 000 throughout, and stage 0 releases 16 cycles after the request drops.
- Watchdog (RESET_SEQ_WDOG_EN, WDOG_CYCLES=64): with no kicks after RUN entry -> reset after 64 cycles and rst_cause=10. With a kick every 32 cycles -> no reset. With sw_rst_req and an expiry on the same edge -> rst_cause=10.
- Async reset: assert rst between clock edges mid-RELEASE -> stage_rst_n=000, seq_done=0 and rst_cause=00 before the next edge.
